// File: rtl/vga_pkg.sv
// Shared VGA definitions: default timing, colour constants and helper functions.
package vga_pkg;

  // Default 640x480@60 timing (pixels / lines)
  localparam int DEF_H_ACTIVE = 32'd640;
  localparam int DEF_H_FP     = 32'd16;
  localparam int DEF_H_SYNC   = 32'd96;
  localparam int DEF_H_BP     = 32'd48;
  localparam int DEF_V_ACTIVE = 32'd480;
  localparam int DEF_V_FP     = 32'd10;
  localparam int DEF_V_SYNC   = 32'd2;
  localparam int DEF_V_BP     = 32'd33;

  // HUD slot geometry: slot k spans HUD_X0+HUD_PITCH*k for HUD_SLOT_W pixels
  localparam int HUD_X0     = 32'd4;
  localparam int HUD_PITCH  = 32'd20;
  localparam int HUD_SLOT_W = 32'd16;
  localparam int HUD_H      = 32'd16;

  typedef logic [8:0] rgb9_t;

  localparam rgb9_t BLACK = 9'o000;
  localparam rgb9_t GREY  = 9'o444;
  localparam rgb9_t GREEN = 9'o070;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Clamp a lives count to the number of HUD slots available
  function automatic logic [2:0] sat_lives(input logic [2:0] l, input int max_l);
    logic [2:0] r;
    if (int'(l) > max_l) r = 3'(max_l);
    else                 r = l;
    return r;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA counters (S0) and registered raw sync / active / position / tick (S1).
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic       latch,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hs,
  output logic       vs,
  output logic       tick
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 32'd1024 || V_TOTAL > 32'd1024) begin : g_total_check
    $fatal(1, "vga_timing: total exceeds 10-bit counter range");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 32'd1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 32'd1);
  localparam logic [10:0] H_ACT11  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT11  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  hcount_r, vcount_r;
  logic [10:0] h11_s, v11_s;
  logic        active_s, hsync_s, vsync_s, latch_s;
  logic [9:0]  x_r, y_r;
  logic        active_r, hs_r, vs_r, tick_r;

  // Compare in 11 bits so a region end of exactly 1024 still works
  assign h11_s    = {1'b0, hcount_r};
  assign v11_s    = {1'b0, vcount_r};
  assign active_s = (h11_s < H_ACT11) && (v11_s < V_ACT11);
  assign hsync_s  = (h11_s >= HS_START) && (h11_s < HS_END);
  assign vsync_s  = (v11_s >= VS_START) && (v11_s < VS_END);
  assign latch_s  = (hcount_r == 10'd0) && (v11_s == V_ACT11);

  // S0: horizontal counter wraps at H_TOTAL and advances the line counter
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_r <= 10'd0;
      vcount_r <= 10'd0;
    end else if (hcount_r == H_LAST) begin
      hcount_r <= 10'd0;
      vcount_r <= (vcount_r == V_LAST) ? 10'd0 : vcount_r + 10'd1;
    end else begin
      hcount_r <= hcount_r + 10'd1;
    end
  end

  // S1: register position, region flags, active-low syncs and the frame tick
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r      <= 10'd0;
      y_r      <= 10'd0;
      active_r <= 1'b0;
      hs_r     <= 1'b1;
      vs_r     <= 1'b1;
      tick_r   <= 1'b0;
    end else begin
      x_r      <= hcount_r;
      y_r      <= vcount_r;
      active_r <= active_s;
      hs_r     <= ~hsync_s;
      vs_r     <= ~vsync_s;
      tick_r   <= latch_s;
    end
  end

  assign latch  = latch_s;
  assign x      = x_r;
  assign y      = y_r;
  assign active = active_r;
  assign hs     = hs_r;
  assign vs     = vs_r;
  assign tick   = tick_r;

endmodule

// File: rtl/vga_sprite_renderer.sv
// Sprite compositor: per-frame shadow latch, hit tests, priority mux, S2 outputs.
module vga_sprite_renderer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int N_SPR       = 32'd4,
  parameter int GRID_LOG2_W = 32'd5,
  parameter int GRID_LOG2_H = 32'd5,
  parameter int MAX_LIVES   = 32'd5,
  parameter int HUD_Y       = 32'd448
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SPR-1:0]      spr_en,
  input  logic [10*N_SPR-1:0]   spr_x,
  input  logic [10*N_SPR-1:0]   spr_y,
  input  logic [6*N_SPR-1:0]    spr_w,
  input  logic [6*N_SPR-1:0]    spr_h,
  input  logic [9*N_SPR-1:0]    spr_rgb,
  input  logic [2:0]            lives,
  output logic [2:0]            vgaR,
  output logic [2:0]            vgaG,
  output logic [2:0]            vgaB,
  output logic                  vgaHs,
  output logic                  vgaVs,
  output logic                  frame_tick
);

  if (N_SPR < 32'd1 || N_SPR > 32'd8) begin : g_nspr_check
    $fatal(1, "vga_sprite_renderer: N_SPR must be 1..8");
  end

  logic       latch_s, active_s, hs_s, vs_s, tick_s;
  logic [9:0] x_s, y_s;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk    (clk),
    .rst    (rst),
    .latch  (latch_s),
    .x      (x_s),
    .y      (y_s),
    .active (active_s),
    .hs     (hs_s),
    .vs     (vs_s),
    .tick   (tick_s)
  );

  logic [N_SPR-1:0] sh_en_r;
  logic [9:0]       sh_x_r   [N_SPR];
  logic [9:0]       sh_y_r   [N_SPR];
  logic [5:0]       sh_w_r   [N_SPR];
  logic [5:0]       sh_h_r   [N_SPR];
  rgb9_t            sh_rgb_r [N_SPR];
  logic [2:0]       sh_lives_r;

  // Shadow copy of the game-side inputs, taken once per frame at vblank start
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_en_r    <= '0;
      sh_lives_r <= 3'd0;
      for (int i = 0; i < N_SPR; i++) begin
        sh_x_r[i]   <= 10'd0;
        sh_y_r[i]   <= 10'd0;
        sh_w_r[i]   <= 6'd0;
        sh_h_r[i]   <= 6'd0;
        sh_rgb_r[i] <= BLACK;
      end
    end else if (latch_s) begin
      sh_en_r    <= spr_en;
      sh_lives_r <= sat_lives(lives, MAX_LIVES);
      for (int i = 0; i < N_SPR; i++) begin
        sh_x_r[i]   <= spr_x[10*i +: 10];
        sh_y_r[i]   <= spr_y[10*i +: 10];
        sh_w_r[i]   <= spr_w[6*i +: 6];
        sh_h_r[i]   <= spr_h[6*i +: 6];
        sh_rgb_r[i] <= spr_rgb[9*i +: 9];
      end
    end
  end

  logic [N_SPR-1:0] hit_s;

  // Per-sprite rectangle test; 11-bit end coordinates so nothing wraps past 1023
  for (genvar i = 0; i < N_SPR; i++) begin : g_hit
    logic [10:0] x_end_s, y_end_s;
    assign x_end_s  = {1'b0, sh_x_r[i]} + {5'b00000, sh_w_r[i]};
    assign y_end_s  = {1'b0, sh_y_r[i]} + {5'b00000, sh_h_r[i]};
    assign hit_s[i] = sh_en_r[i]
                    && (x_s >= sh_x_r[i]) && ({1'b0, x_s} < x_end_s)
                    && (y_s >= sh_y_r[i]) && ({1'b0, y_s} < y_end_s);
  end

  logic hud_s, grid_s, hud_row_s;
  rgb9_t spr_pix_s, pix_s;

  assign hud_row_s = (int'(y_s) >= HUD_Y) && (int'(y_s) < HUD_Y + HUD_H);
  assign grid_s    = (x_s[GRID_LOG2_W-1:0] == {GRID_LOG2_W{1'b0}})
                  || (y_s[GRID_LOG2_H-1:0] == {GRID_LOG2_H{1'b0}});

  // HUD: OR of all lit slots on the HUD rows
  always_comb begin
    hud_s = 1'b0;
    for (int k = 0; k < MAX_LIVES; k++) begin
      hud_s = hud_s | (hud_row_s
                    && (k < int'(sh_lives_r))
                    && (int'(x_s) >= HUD_X0 + HUD_PITCH * k)
                    && (int'(x_s) <  HUD_X0 + HUD_PITCH * k + HUD_SLOT_W));
    end
  end

  // Sprite priority: scan high to low so the lowest hitting index wins
  always_comb begin
    spr_pix_s = BLACK;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      spr_pix_s = hit_s[i] ? sh_rgb_r[i] : spr_pix_s;
    end
  end

  // Layer select: sprite > HUD > grid > black, blanked outside the active area
  always_comb begin
    pix_s = BLACK;
    if (!active_s)       pix_s = BLACK;
    else if (|hit_s)     pix_s = spr_pix_s;
    else if (hud_s)      pix_s = GREEN;
    else if (grid_s)     pix_s = GREY;
    else                 pix_s = BLACK;
  end

  rgb9_t rgb_r;
  logic  hs_r, vs_r, tick_r;

  // S2: final registered outputs, keeping colour, syncs and tick aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r  <= BLACK;
      hs_r   <= 1'b1;
      vs_r   <= 1'b1;
      tick_r <= 1'b0;
    end else begin
      rgb_r  <= pix_s;
      hs_r   <= hs_s;
      vs_r   <= vs_s;
      tick_r <= tick_s;
    end
  end

  assign vgaR       = rgb_r[8:6];
  assign vgaG       = rgb_r[5:3];
  assign vgaB       = rgb_r[2:0];
  assign vgaHs      = hs_r;
  assign vgaVs      = vs_r;
  assign frame_tick = tick_r;

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Scoreboard bench for vga_sprite_renderer using a reduced timing set.
module tb_vga_sprite_renderer;

  localparam int HA = 128, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 96,  VFP = 2, VSY = 2, VBP = 4;
  localparam int NS = 4, GLW = 4, GLH = 4, ML = 5, HUDY = 80;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FR = HT * VT;
  localparam int LATCH_POS = VA * HT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS-1:0]    en_a;
  logic [9:0]       sx_a [NS];
  logic [9:0]       sy_a [NS];
  logic [5:0]       sw_a [NS];
  logic [5:0]       sh_a [NS];
  logic [8:0]       rgb_a[NS];
  logic [2:0]       lives;

  logic [10*NS-1:0] spr_x, spr_y;
  logic [6*NS-1:0]  spr_w, spr_h;
  logic [9*NS-1:0]  spr_rgb;
  logic [2:0]       vgaR, vgaG, vgaB;
  logic             vgaHs, vgaVs, frame_tick;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      spr_x[10*i +: 10]  = sx_a[i];
      spr_y[10*i +: 10]  = sy_a[i];
      spr_w[6*i +: 6]    = sw_a[i];
      spr_h[6*i +: 6]    = sh_a[i];
      spr_rgb[9*i +: 9]  = rgb_a[i];
    end
  end

  vga_sprite_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .N_SPR(NS), .GRID_LOG2_W(GLW), .GRID_LOG2_H(GLH),
    .MAX_LIVES(ML), .HUD_Y(HUDY)
  ) dut (
    .clk(clk), .rst(rst), .spr_en(en_a), .spr_x(spr_x), .spr_y(spr_y),
    .spr_w(spr_w), .spr_h(spr_h), .spr_rgb(spr_rgb), .lives(lives),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB), .vgaHs(vgaHs), .vgaVs(vgaVs),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         h;
    int         v;
    int         frame;
    logic [11:0] outv;   // {rgb, hs, vs, tick}
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   n     = 0;       // positions processed since reset release
  bit   rst_edge = 1'b0;
  int   cap[int];

  // Reference shadow state
  int m_en[NS], m_x[NS], m_y[NS], m_w[NS], m_h[NS], m_rgb[NS];
  int m_lives;

  function automatic logic [8:0] ref_rgb(input int x, input int y);
    int lv;
    if (x >= HA || y >= VA) return 9'o000;
    for (int i = 0; i < NS; i++)
      if (m_en[i] != 0 && x >= m_x[i] && x < m_x[i] + m_w[i] && y >= m_y[i] && y < m_y[i] + m_h[i])
        return 9'(m_rgb[i]);
    lv = (m_lives > ML) ? ML : m_lives;
    if (y >= HUDY && y < HUDY + 16)
      for (int k = 0; k < lv; k++)
        if (x >= 4 + 20 * k && x < 20 + 20 * k) return 9'o070;
    if ((x % (1 << GLW)) == 0 || (y % (1 << GLH)) == 0) return 9'o444;
    return 9'o000;
  endfunction

  // Reference model: one expected output per clock, from position arithmetic
  initial begin
    exp_t e;
    int pos, h, v;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        n = 0;
        rst_edge = 1'b1;
        m_lives = 0;
        for (int i = 0; i < NS; i++) begin
          m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0; m_rgb[i] = 0;
        end
      end else begin
        rst_edge = 1'b0;
        pos = n % FR;
        h = pos % HT;
        v = pos / HT;
        e.h = h; e.v = v; e.frame = n / FR;
        e.outv = {ref_rgb(h, v),
                  !(h >= HA + HFP && h < HA + HFP + HSY),
                  !(v >= VA + VFP && v < VA + VFP + VSY),
                  (h == 0 && v == VA)};
        q.push_back(e);
        if (h == 0 && v == VA) begin
          m_lives = int'(lives);
          for (int i = 0; i < NS; i++) begin
            m_en[i] = int'(en_a[i]); m_x[i] = int'(sx_a[i]); m_y[i] = int'(sy_a[i]);
            m_w[i] = int'(sw_a[i]); m_h[i] = int'(sh_a[i]); m_rgb[i] = int'(rgb_a[i]);
          end
        end
        n++;
      end
    end
  end

  // Monitor: compares every presented output against the scoreboard
  initial begin
    exp_t e;
    logic [11:0] got;
    int cyc = 0, last_tick = 0;
    bit tick_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      got = {vgaR, vgaG, vgaB, vgaHs, vgaVs, frame_tick};
      if (rst_edge) begin
        tick_valid = 1'b0;
        total++;
        if (got !== 12'b000000000_1_1_0) begin
          bad++;
          $display("FAIL reset_values got=%b required=%b", got, 12'b000000000_1_1_0);
        end
      end else if (q.size() >= 2) begin
        e = q.pop_front();
        total++;
        if (got !== e.outv) begin
          bad++;
          $display("FAIL pixel f=%0d h=%0d v=%0d got={rgb=%o hs=%b vs=%b tick=%b} required={rgb=%o hs=%b vs=%b tick=%b}",
                   e.frame, e.h, e.v, got[11:3], got[2], got[1], got[0],
                   e.outv[11:3], e.outv[2], e.outv[1], e.outv[0]);
        end
        if (e.frame <= 2 && !cap.exists(e.frame * (1 << 20) + e.v * 1024 + e.h))
          cap[e.frame * (1 << 20) + e.v * 1024 + e.h] = int'(got[11:3]);
        if (frame_tick === 1'b1) begin
          if (tick_valid) begin
            total++;
            if (cyc - last_tick != FR) begin
              bad++;
              $display("FAIL tick_period got=%0d required=%0d", cyc - last_tick, FR);
            end
          end
          last_tick = cyc;
          tick_valid = 1'b1;
        end
      end
    end
  end

  task automatic wait_pos(input int p);
    int guard = 0;
    while (n < p && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (n != p) begin
      bad++;
      $display("FAIL wait_pos got=%0d required=%0d", n, p);
    end
  endtask

  task automatic check_px(input int f, input int x, input int y, input logic [8:0] req, input string nm);
    int key;
    key = f * (1 << 20) + y * 1024 + x;
    total++;
    if (!cap.exists(key)) begin
      bad++;
      $display("FAIL %s not_observed f=%0d x=%0d y=%0d required=%o", nm, f, x, y, req);
    end else if (cap[key] != int'(req)) begin
      bad++;
      $display("FAIL %s f=%0d x=%0d y=%0d got=%o required=%o", nm, f, x, y, cap[key], req);
    end
  endtask

  task automatic set_spr(input int i, input logic e, input int x, input int y,
                         input int w, input int h, input logic [8:0] c);
    en_a[i] = e; sx_a[i] = 10'(x); sy_a[i] = 10'(y);
    sw_a[i] = 6'(w); sh_a[i] = 6'(h); rgb_a[i] = c;
  endtask

  task automatic rand_spr();
    int i;
    i = $urandom_range(0, NS - 1);
    en_a[i]  = ($urandom_range(0, 3) != 0);
    sx_a[i]  = ($urandom_range(0, 7) == 0) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom_range(0, HT - 1));
    sy_a[i]  = 10'($urandom_range(0, VT - 1));
    sw_a[i]  = 6'($urandom_range(0, 63));
    sh_a[i]  = 6'($urandom_range(0, 63));
    rgb_a[i] = 9'($urandom);
    lives    = 3'($urandom_range(0, 7));
  endtask

  // Stimulus: directed frames, random frames, mid-line reset, spot checks
  initial begin
    rst = 1'b1;
    set_spr(0, 1'b1, 100, 50, 16, 16, 9'o777);
    set_spr(1, 1'b1, 108, 58, 16, 16, 9'o007);
    set_spr(2, 1'b1, 1020, 10, 20, 20, 9'o070);
    set_spr(3, 1'b0, 0, 0, 0, 0, 9'o000);
    lives = 3'd3;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Mid-frame move: must not show until after the next latch
    wait_pos(FR + 3000);
    set_spr(0, 1'b1, 20, 50, 16, 16, 9'o700);
    set_spr(1, 1'b1, 28, 58, 16, 16, 9'o007);
    lives = 3'd7;

    // Change on the latch cycle itself: the new value is captured
    wait_pos(FR + LATCH_POS);
    set_spr(3, 1'b1, 2, 2, 8, 8, 9'o123);
    @(negedge clk);

    while (n < 3 * FR + 5000) begin
      repeat ($urandom_range(50, 600)) @(negedge clk);
      rand_spr();
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_pos(FR + 2000);
    repeat (4) @(negedge clk);

    check_px(1, 100, 50, 9'o777, "spr0_topleft");
    check_px(1, 115, 65, 9'o777, "spr0_botright");
    check_px(1, 116, 50, 9'o000, "spr0_right_edge");
    check_px(1, 112, 62, 9'o777, "overlap_prio0");
    check_px(1, 120, 70, 9'o007, "spr1_only");
    check_px(1, 5, 15, 9'o000, "no_wrap");
    check_px(1, 0, 12, 9'o444, "no_wrap_grid");
    check_px(1, 32, 1, 9'o444, "grid_32_1");
    check_px(1, 4, 81, 9'o070, "hud_slot0");
    check_px(1, 59, 95, 9'o070, "hud_slot2_end");
    check_px(1, 60, 81, 9'o000, "hud_gap");
    check_px(1, 70, 81, 9'o000, "hud_no_slot3");
    check_px(2, 84, 81, 9'o070, "hud_sat_slot4");
    check_px(2, 100, 81, 9'o000, "hud_sat_no_slot5");
    check_px(2, 30, 60, 9'o700, "overlap_red");
    check_px(2, 40, 70, 9'o007, "spr1_moved");
    check_px(2, 100, 50, 9'o000, "spr0_old_pos");
    check_px(2, 2, 2, 9'o123, "latch_cycle_capture");
    check_px(2, 9, 9, 9'o123, "latch_spr3_end");
    check_px(2, 10, 2, 9'o000, "latch_spr3_edge");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
